// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector with a
// registered one-cycle detect pulse. Overlapping or non-overlapping matching
// is chosen per match, and matches are optionally counted.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   in_valid, in qualified serial bit stream, MSB of the pattern arrives first
//   overlap      1 = a match suffix may start the next match, 0 = restart
//   cfg_load     one-cycle pulse loading cfg_pattern (wins over in_valid)
//   cfg_pattern  new pattern; bit [PATTERN_LEN-1] is matched first
//   cnt_clr      synchronous clear of match_count (wins over an increment)
//   detect       one-cycle pulse after the edge sampling the last pattern bit
//   match_count  saturating match counter
//   cur_pattern  active pattern register
//
// Build option: define SEQ_DET_MATCH_CNT_EN to include the match counter.
// Without it match_count is tied to zero and cnt_clr is ignored.
// PATTERN_LEN must lie in 2..32.

module seq_detector_param #(
    parameter int                     PATTERN_LEN     = 6,
    parameter logic [PATTERN_LEN-1:0] DEFAULT_PATTERN = PATTERN_LEN'(6'b110110),
    parameter int                     CNT_W           = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in,
    input  logic                   overlap,
    input  logic                   cfg_load,
    input  logic [PATTERN_LEN-1:0] cfg_pattern,
    input  logic                   cnt_clr,
    output logic                   detect,
    output logic [CNT_W-1:0]       match_count,
    output logic [PATTERN_LEN-1:0] cur_pattern
);

    // fill counts bits sampled since the last restart, saturating at
    // PATTERN_LEN; it needs to represent the value PATTERN_LEN itself.
    localparam int                FILL_W    = $clog2(PATTERN_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN);

    logic [PATTERN_LEN-1:0] pattern;
    logic [PATTERN_LEN-1:0] history;
    logic [FILL_W-1:0]      fill;

    logic [PATTERN_LEN-1:0] pattern_nxt;
    logic [PATTERN_LEN-1:0] history_nxt;
    logic [FILL_W-1:0]      fill_nxt;
    logic [PATTERN_LEN-1:0] hist_shift;
    logic [FILL_W-1:0]      fill_inc;
    logic                   match;

    // The oldest history bit falls off the shift and is never read.
    logic unused_hist_msb;
    assign unused_hist_msb = history[PATTERN_LEN-1];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern <= DEFAULT_PATTERN;
            history <= '0;
            fill    <= '0;
            detect  <= 1'b0;
        end else begin
            pattern <= pattern_nxt;
            history <= history_nxt;
            fill    <= fill_nxt;
            detect  <= match;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        hist_shift  = {history[PATTERN_LEN-2:0], in};
        fill_inc    = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);

        // Match is judged on the post-sample history; fill gating keeps the
        // zeroed history from matching an all-zero (or zero-prefixed) pattern.
        match       = in_valid && !cfg_load &&
                      (fill_inc == FILL_FULL) && (hist_shift == pattern);

        pattern_nxt = pattern;
        history_nxt = history;
        fill_nxt    = fill;

        if (cfg_load) begin
            // Any bit presented alongside a load is dropped.
            pattern_nxt = cfg_pattern;
            history_nxt = '0;
            fill_nxt    = '0;
        end else if (in_valid) begin
            history_nxt = hist_shift;
            // Non-overlapping: the next match needs PATTERN_LEN fresh bits.
            // The history bits are left in place; the cleared fill masks them.
            fill_nxt    = (match && !overlap) ? '0 : fill_inc;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cur_pattern = pattern;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (cnt_clr) begin
            count <= '0;
        end else if (match && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign match_count = count;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
`endif

endmodule
